// File: rtl/dram_tester_pkg.sv
// -----------------------------------------------------------------------------
// dram_tester_pkg
// Shared definitions for the DRAM pattern tester:
//   - state_e          : sequencer states (IDLE / WRITE / READ / DONE)
//   - MODE_*           : pattern select encodings
//   - LFSR_POLY/SEED   : 32-bit Galois LFSR, x^32+x^22+x^2+x+1, seed 1
//   - lfsr_step()      : one left-shift Galois LFSR step
// -----------------------------------------------------------------------------
package dram_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_ADDR  = 2'd0;
  localparam logic [1:0] MODE_CHECK = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_NADDR = 2'd3;

  // Feedback taps below x^32: x^22, x^2, x^1, x^0.
  localparam logic [31:0] LFSR_POLY = 32'h0040_0007;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  // Shift left; when the bit falling off the top is set, fold in the taps.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/dram_pattern_gen.sv
// -----------------------------------------------------------------------------
// dram_pattern_gen
// Maps (mode, word index, LFSR state) to the data word for that index. Shared by
// the write and read phases so that reads reproduce the written sequence.
// Optional feature macro: DRAM_TESTER_LFSR_EN (builds the LFSR; otherwise the
// LFSR mode falls back to address-as-data and no LFSR state exists).
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   seed_i      : load the LFSR seed (state for word 0)
//   advance_i   : step the LFSR to the next word
//   mode_i      : pattern select
//   index_i     : word index
//   data_o      : data word; reflects this cycle's seed/advance strobe
// -----------------------------------------------------------------------------
module dram_pattern_gen
  import dram_tester_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              seed_i,
  input  logic              advance_i,
  input  logic [1:0]        mode_i,
  input  logic [IDX_W-1:0]  index_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] idx_data;
  logic [DATA_W-1:0] lfsr_data;

  assign idx_data = DATA_W'(index_i);

`ifdef DRAM_TESTER_LFSR_EN
  localparam int REP = (DATA_W + 31) / 32;

  logic [31:0]       lfsr_q;
  logic [31:0]       lfsr_d;
  logic [REP*32-1:0] lfsr_rep;

  // The data output uses the post-strobe value so the word issued in the
  // seeding/advancing cycle already carries the right pattern.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_i) begin
      lfsr_d = LFSR_SEED;
    end else if (advance_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_rep  = {REP{lfsr_d}};
  assign lfsr_data = lfsr_rep[DATA_W-1:0];
`else
  logic unused_lfsr_inputs;
  assign unused_lfsr_inputs = ^{clk, rstn, seed_i, advance_i};
  assign lfsr_data          = idx_data;
`endif

  always_comb begin
    data_o = idx_data;
    case (mode_i)
      MODE_ADDR:  data_o = idx_data;
      MODE_CHECK: data_o = {(DATA_W/8){index_i[0] ? 8'hF0 : 8'h0F}};
      MODE_LFSR:  data_o = lfsr_data;
      MODE_NADDR: data_o = ~idx_data;
      default:    data_o = idx_data;
    endcase
  end

endmodule

// File: rtl/dram_pattern_tester.sv
// -----------------------------------------------------------------------------
// dram_pattern_tester
// Writes WORDS pattern words from BASE_ADDR, reads them back, checks each word
// and reports a verdict. Optional feature macro: DRAM_TESTER_LFSR_EN (see
// dram_pattern_gen).
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   start, mode      : start pulse (ignored while busy), pattern select
//   busy, done, pass : run in progress, verdict valid, verdict good
//   err_count        : saturating mismatch count
//   first_err_addr   : address of the first mismatch (0 if none)
//   addr_dram, din_dram, rw_dram, valid_dram : request to the controller
//   dout_dram, ready_dram                    : completion from the controller
// -----------------------------------------------------------------------------
module dram_pattern_tester
  import dram_tester_pkg::*;
#(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 32,
  parameter int WORDS     = 16,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_STEP = 4,
  parameter int ERR_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] addr_dram,
  output logic [DATA_W-1:0] din_dram,
  output logic              rw_dram,
  output logic              valid_dram,
  input  logic [DATA_W-1:0] dout_dram,
  input  logic              ready_dram
);

  localparam int                IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(ADDR_STEP);
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};

  state_e              state_q;
  logic [1:0]          mode_q;
  logic [IDX_W-1:0]    idx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic                rw_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [ERR_W-1:0]    err_q;
  logic [ERR_W-1:0]    err_d;
  logic [ADDR_W-1:0]   fea_q;
  logic [ADDR_W-1:0]   fea_d;

  logic                accept;
  logic                issue;
  logic                is_last;
  logic                mismatch;
  logic                gen_seed;
  logic                gen_advance;
  logic [1:0]          gen_mode;
  logic [IDX_W-1:0]    gen_index;
  logic [DATA_W-1:0]   gen_data;

  // Requests are issued at the start edge (word 0) and in the one idle cycle
  // after each completion. The only idle-cycle issue with index 0 is the first
  // read, which reseeds the generator; every other issue advances it. During a
  // pending read the generator is left alone, so its output is the expected word.
  always_comb begin
    accept      = start && (state_q == ST_IDLE || state_q == ST_DONE);
    issue       = (state_q == ST_WRITE || state_q == ST_READ) && !valid_q;
    is_last     = (idx_q == LAST_IDX);
    gen_seed    = accept || (issue && idx_q == '0);
    gen_advance = issue && (idx_q != '0);
    gen_mode    = accept ? mode : mode_q;
    gen_index   = accept ? '0 : idx_q;
    mismatch    = (state_q == ST_READ) && valid_q && ready_dram && (dout_dram != gen_data);

    err_d = err_q;
    fea_d = fea_q;
    if (mismatch) begin
      if (err_q != ERR_MAX) begin
        err_d = err_q + ERR_W'(1);
      end
      // The counter never returns to zero within a run, so zero means "no
      // mismatch yet" even after saturation.
      if (err_q == '0) begin
        fea_d = addr_q;
      end
    end
  end

  dram_pattern_gen #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_gen (
    .clk       (clk),
    .rstn      (rstn),
    .seed_i    (gen_seed),
    .advance_i (gen_advance),
    .mode_i    (gen_mode),
    .index_i   (gen_index),
    .data_o    (gen_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ADDR;
      idx_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fea_q   <= '0;
    end else if (accept) begin
      state_q <= ST_WRITE;
      mode_q  <= mode;
      idx_q   <= '0;
      addr_q  <= BASE_A;
      din_q   <= gen_data;
      rw_q    <= 1'b1;
      valid_q <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fea_q   <= '0;
    end else begin
      case (state_q)
        ST_WRITE, ST_READ: begin
          if (valid_q) begin
            if (ready_dram) begin
              valid_q <= 1'b0;
              err_q   <= err_d;
              fea_q   <= fea_d;
              if (is_last) begin
                if (state_q == ST_WRITE) begin
                  state_q <= ST_READ;
                  idx_q   <= '0;
                  addr_q  <= BASE_A;
                  rw_q    <= 1'b0;
                end else begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == '0);
                end
              end else begin
                idx_q  <= idx_q + IDX_W'(1);
                addr_q <= addr_q + STEP_A;
              end
            end
          end else begin
            // Idle cycle after a completion: raise the next request.
            valid_q <= 1'b1;
            din_q   <= gen_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = fea_q;
  assign addr_dram      = addr_q;
  assign din_dram       = din_q;
  assign rw_dram        = rw_q;
  assign valid_dram     = valid_q;

endmodule

// File: doc/dram_pattern_tester.md
# dram_pattern_tester

Self-checking DRAM traffic generator on the `valid_dram`/`ready_dram` request interface of the DRAM controller wrapper. On `start` it writes `WORDS` words of a selectable pattern from `BASE_ADDR`, reads them all back, compares each word and reports a pass/fail verdict, an error count and the first failing address. It replaces hand-written stimulus state machines in DRAM benches and can also be synthesised for on-board memory bring-up.

## Interface
- `ADDR_W`, 27, DRAM address width
- `DATA_W`, 32, DRAM data width; must be a multiple of 8
- `WORDS`, 16, words per pass; must be ≥ 1
- `BASE_ADDR`, 0, address of word 0
- `ADDR_STEP`, 4, address increment per word (byte addressing)
- `ERR_W`, 16, width of the error counter
- `clk`  in  1  system clock; the block uses this single clock
- `rstn`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle start pulse; ignored while `busy`
- `mode`  in  2  pattern select, latched on an accepted `start`
- `busy`  out  1  high from the accepted `start` until the verdict is available
- `done`  out  1  verdict valid; held until the next accepted `start`
- `pass`  out  1  `done` && `err_count == 0`
- `err_count`  out  ERR_W  mismatching reads; saturates at all-ones
- `first_err_addr`  out  ADDR_W  address of the first mismatch; 0 if none
- `addr_dram`  out  ADDR_W  request address
- `din_dram`  out  DATA_W  write data
- `rw_dram`  out  1  1 = write, 0 = read
- `valid_dram`  out  1  request valid
- `dout_dram`  in  DATA_W  read data; valid in the cycle `ready_dram` is high
- `ready_dram`  in  1  one-cycle completion pulse

## Operation
- States and transitions:
  - IDLE → WRITE on `start`.
  - WRITE → READ after the ready for word `WORDS-1`.
  - READ → DONE after the ready for word `WORDS-1`.
  - DONE → WRITE on `start`.
- Accepting `start` in IDLE or DONE:
  - Clears `err_count`, `first_err_addr`, `done` and the word index.
  - Latches `mode`.
  - Seeds the pattern generator.
- Word `i` has address `BASE_ADDR + i*ADDR_STEP`, truncated to `ADDR_W`.
- Patterns; the generator is reseeded at entry to READ so that reads reproduce the write sequence:
  - `mode` 0: address-as-data. Index `i`, zero-extended or truncated to `DATA_W`.
  - `mode` 1: checkerboard. Byte `8'h0F` replicated for even `i`, `8'hF0` replicated for odd `i`.
  - `mode` 2: LFSR. 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seed `32'h1`, advanced once per word. Output is replicated or truncated to `DATA_W`.
  - `mode` 3: inverted address. Bitwise NOT of the `mode` 0 data.
- Read check: on each read ready, compare `dout_dram` against the expected word.
  - On mismatch, increment `err_count` (saturating).
  - On the first mismatch only, capture that word's address into `first_err_addr`.

## Timing
- Reset values: `valid_dram`, `rw_dram`, `busy`, `done`, `pass` are 0; `addr_dram`, `din_dram`, `err_count`, `first_err_addr` are 0. Reset takes effect asynchronously, including mid-transaction: `valid_dram` drops immediately and the pending request is abandoned.
- All outputs are registered.
- `busy` and the first request (`valid_dram` = 1) are asserted at the edge after `start` is sampled.
- `addr_dram`, `din_dram` and `rw_dram` are stable while `valid_dram` is high.
- Handshake:
  - At the edge where `ready_dram` is sampled high, `valid_dram` goes 0.
  - The next request is asserted at the following edge, giving exactly one idle cycle between transactions.
  - A `ready_dram` seen while `valid_dram` = 0 is ignored.
- Verdict: at the edge that samples the last read ready, `busy` falls and `done`, `pass`, the final `err_count` and `first_err_addr` update together.
- `start` coinciding with `ready_dram` while busy is ignored.
- Minimum run length: 2·`WORDS` transactions × (controller latency + 1 idle cycle) + 1 cycle.

## Configuration
- `DRAM_TESTER_LFSR_EN` defined: the LFSR is built and `mode` 2 behaves as specified above.
- `DRAM_TESTER_LFSR_EN` undefined: no LFSR logic is built and `mode` 2 behaves exactly as `mode` 0.

## Structure
- Package `dram_tester_pkg` holds:
  - state encoding (IDLE/WRITE/READ/DONE)
  - mode constants (`MODE_ADDR`, `MODE_CHECK`, `MODE_LFSR`, `MODE_NADDR`)
  - LFSR polynomial and seed constants
- Sub-module `dram_pattern_gen`: holds the index-to-data mapping and the LFSR register. It has `seed` and `advance` strobes and a `DATA_W` output, and is shared by the write and read phases.

## Test plan
- `WORDS`=2, `mode` 1, ideal memory model with ready 3 cycles after valid:
  - Writes are `32'h0F0F0F0F` @0 and `32'hF0F0F0F0` @4.
  - Reads follow; `done`=1, `pass`=1, `err_count`=0.
- `mode` 0, `WORDS`=16, model corrupts the read at address 0x14 to `32'hDEAD`: `err_count`=1, `first_err_addr`=0x14, `pass`=0.
- Model returns constant `32'h0` for all reads in `mode` 3, `WORDS`=16:
  - `err_count`=16 and `first_err_addr`=0.
  - With `ERR_W`=3, `err_count` saturates at 7.
- `mode` 2 with `DRAM_TESTER_LFSR_EN` defined:
  - First two writes are `32'h1` and `32'h2`, and all reads pass.
  - With the macro undefined, write data equals `mode` 0 data.
- Handshake checks:
  - Hold `ready_dram` low for 50 cycles: address and data stay stable.
  - A stray `ready_dram` pulse in the idle gap is ignored.
  - `start` pulsed mid-run is ignored.
- Assert `rstn`=0 during the 5th write: all outputs return to reset values immediately. A new `start` after release restarts from word 0.
